// File: rtl/miner_pkg.sv
// Shared miner types: nonce width, UART frame length and the TX state encoding.
// GOLDEN_NONCE_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
package miner_pkg;
  localparam int NONCE_W = 32;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
  localparam int UART_FRAME_BYTES = 5;
`else
  localparam int UART_FRAME_BYTES = 4;
`endif
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/golden_nonce_fifo.sv
// Synchronous FIFO. Full/empty derive from the occupancy count; a pop frees the
// slot for a push on the same edge.
module golden_nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int LOG2  = 3
) (
  input  logic             hash_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    count
);
  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2-1:0]  wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{LOG2{1'b0}}, do_push} - {{LOG2{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge hash_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces and sends each as an 8N1 UART frame, nonce bytes MSB-first.
// Define GOLDEN_NONCE_CHECKSUM_EN to append an XOR checksum byte to every frame.
module golden_nonce_uart_tx
  import miner_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_LOG2    = 3
) (
  input  logic                 hash_clk,
  input  logic                 reset_n,
  input  logic                 golden_nonce_valid,
  input  logic [NONCE_W-1:0]   golden_nonce,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [FIFO_LOG2:0]   fifo_count,
  output logic [7:0]           drop_count
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(UART_FRAME_BYTES - 1);

  tx_state_t          state, state_nxt;
  logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
  logic [2:0]         bit_idx, bit_nxt;
  logic [2:0]         byte_idx, byte_nxt;
  logic [NONCE_W-1:0] shreg, shreg_nxt;
  logic [NONCE_W-1:0] fifo_rdata;
  logic [7:0]         cur_byte, fill_byte;
  logic               tx_nxt, pop, full, empty, bit_end, drop;

  golden_nonce_fifo #(.WIDTH(NONCE_W), .LOG2(FIFO_LOG2)) u_fifo (
    .hash_clk (hash_clk),
    .reset_n  (reset_n),
    .push     (golden_nonce_valid),
    .wdata    (golden_nonce),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign cur_byte = shreg[31:24];
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign drop     = golden_nonce_valid & full & ~pop;

`ifdef GOLDEN_NONCE_CHECKSUM_EN
  logic [7:0] csum, csum_nxt;
  // Checksum rides in behind the nonce bytes as the shift register empties.
  assign fill_byte = csum;
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) csum <= '0;
    else          csum <= csum_nxt;
  end
`else
  assign fill_byte = 8'h00;
`endif

  always_comb begin
    state_nxt = state;
    baud_nxt  = (state == IDLE || bit_end) ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    shreg_nxt = shreg;
    tx_nxt    = uart_tx;
    pop       = 1'b0;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
    csum_nxt  = csum;
`endif
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        shreg_nxt = fifo_rdata;
        byte_nxt  = '0;
        tx_nxt    = 1'b0;
        state_nxt = START;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
        csum_nxt  = fifo_rdata[31:24] ^ fifo_rdata[23:16] ^ fifo_rdata[15:8] ^ fifo_rdata[7:0];
`endif
      end
      START: if (bit_end) begin
        bit_nxt   = '0;
        tx_nxt    = cur_byte[0];
        state_nxt = DATA;
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end else begin
          bit_nxt = bit_idx + 3'd1;
          tx_nxt  = cur_byte[bit_idx + 3'd1];
        end
      end
      STOP: if (bit_end) begin
        if (byte_idx == LAST_BYTE) begin
          state_nxt = IDLE;
        end else begin
          byte_nxt  = byte_idx + 3'd1;
          shreg_nxt = {shreg[23:0], fill_byte};
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      shreg    <= shreg_nxt;
      uart_tx  <= tx_nxt;
      busy     <= (state != IDLE) | (fifo_count != '0);
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: a UART receiver decodes the line and frames are
// compared with nonce/checksum values predicted from a queue-based model.
module tb_golden_nonce_uart_tx;
  localparam int CPB   = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;
`ifdef GOLDEN_NONCE_CHECKSUM_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif
  localparam int FBT = FB * 10 * CPB;

  logic        hash_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        golden_nonce_valid = 1'b0;
  logic [31:0] golden_nonce = '0;
  logic        uart_tx, busy;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;

  int          n_assert = 0;
  int          n_fail = 0;
  int          ferr = 0;
  int          drop_exp = 0;
  int unsigned cyc = 0;
  bit          rst_seen = 1'b0;
  logic [39:0] rx_q[$];
  logic [39:0] exp_q[$];
  int unsigned rx_start[$];

  golden_nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(LOG2)) dut (
    .hash_clk           (hash_clk),
    .reset_n            (reset_n),
    .golden_nonce_valid (golden_nonce_valid),
    .golden_nonce       (golden_nonce),
    .uart_tx            (uart_tx),
    .busy               (busy),
    .fifo_count         (fifo_count),
    .drop_count         (drop_count)
  );

  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cyc <= cyc + 1;
  always @(negedge reset_n) rst_seen = 1'b1;

  function automatic logic [39:0] ef(input logic [31:0] n);
    if (FB == 5) return {n, n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]};
    else         return {8'h00, n};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge hash_clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin tick(); k++; end
    check("frame_count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 2 * FBT) begin tick(); k++; end
    check(tag, busy, 1'b0);
  endtask

  task automatic compare_frames(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check(tag, rx_q[i], exp_q[i]);
  endtask

  // Line receiver: samples each bit in the middle of its bit time.
  initial begin : mon
    logic        last;
    logic [39:0] fr;
    logic [7:0]  b;
    bit          bad;
    int unsigned st;
    last = 1'b1;
    forever begin
      @(negedge hash_clk);
      if (reset_n && last && !uart_tx) begin
        st = cyc; rst_seen = 1'b0; fr = '0; bad = 1'b0; b = '0;
        for (int j = 0; j < FB; j++) begin
          if (j == 0) repeat (CPB / 2) @(negedge hash_clk);
          else        repeat (CPB) @(negedge hash_clk);
          if (uart_tx !== 1'b0) bad = 1'b1;
          for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge hash_clk);
            b[k] = uart_tx;
          end
          repeat (CPB) @(negedge hash_clk);
          if (uart_tx !== 1'b1) bad = 1'b1;
          fr = {fr[31:0], b};
        end
        if (!rst_seen) begin
          if (bad) ferr++;
          rx_q.push_back(fr);
          rx_start.push_back(st);
        end
      end
      last = uart_tx;
    end
  end

  initial begin : watchdog
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] n;
    int mx;
    int occ;
    int unsigned c0;
    int k;

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_count, 0);
    reset_n = 1'b1;
    tick(2);

    // Single nonce
    rx_q.delete(); rx_start.delete(); exp_q.delete();
    golden_nonce = 32'h1234ABCD; golden_nonce_valid = 1'b1;
    exp_q.push_back(ef(32'h1234ABCD));
    tick();
    golden_nonce_valid = 1'b0;
    check("single_count_e0", fifo_count, 1);
    check("single_tx_e0", uart_tx, 1'b1);
    tick();
    check("single_start_bit", uart_tx, 1'b0);
    check("single_count_e1", fifo_count, 0);
    tick(FBT - 1);
    check("single_busy_in_frame", busy, 1'b1);
    tick(3);
    check("single_busy_after", busy, 1'b0);
    wait_frames(1, 10);
    compare_frames("single_frame");

    // Back-to-back
    rx_q.delete(); rx_start.delete(); exp_q.delete();
    mx = 0;
    for (int i = 1; i <= 3; i++) begin
      golden_nonce = 32'(i); golden_nonce_valid = 1'b1;
      exp_q.push_back(ef(32'(i)));
      tick();
      if (int'(fifo_count) > mx) mx = int'(fifo_count);
    end
    golden_nonce_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (int'(fifo_count) > mx) mx = int'(fifo_count);
    end
    check("b2b_peak_count", mx, 2);
    wait_frames(3, 3 * FBT + 50);
    compare_frames("b2b_frame");
    if (rx_start.size() == 3) begin
      check("b2b_gap_1", rx_start[1] - rx_start[0], FBT + 1);
      check("b2b_gap_2", rx_start[2] - rx_start[1], FBT + 1);
    end
    wait_idle("b2b_idle");

    // Overflow while a frame is on the line
    rx_q.delete(); rx_start.delete(); exp_q.delete();
    n = $urandom; golden_nonce = n; golden_nonce_valid = 1'b1;
    exp_q.push_back(ef(n));
    tick();
    golden_nonce_valid = 1'b0;
    tick(10);
    occ = 0;
    for (int i = 0; i < 8; i++) begin
      n = $urandom; golden_nonce = n; golden_nonce_valid = 1'b1;
      if (occ < DEPTH) begin occ++; exp_q.push_back(ef(n)); end
      else drop_exp++;
      tick();
    end
    golden_nonce_valid = 1'b0;
    check("ovf_drop", drop_count, drop_exp);
    check("ovf_count", fifo_count, DEPTH);
    wait_frames(5, 5 * FBT + 50);
    compare_frames("ovf_frame");
    wait_idle("ovf_idle");

    // Push on the exact edge IDLE pops from a full FIFO
    rx_q.delete(); rx_start.delete(); exp_q.delete();
    n = $urandom; golden_nonce = n; golden_nonce_valid = 1'b1;
    exp_q.push_back(ef(n));
    tick();
    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) begin
      n = $urandom; golden_nonce = n;
      exp_q.push_back(ef(n));
      tick();
    end
    golden_nonce_valid = 1'b0;
    check("fp_full", fifo_count, DEPTH);
    k = 0;
    while (cyc != c0 + FBT + 1 && k < 2 * FBT) begin tick(); k++; end
    n = $urandom; golden_nonce = n; golden_nonce_valid = 1'b1;
    exp_q.push_back(ef(n));
    tick();
    golden_nonce_valid = 1'b0;
    check("fp_drop_unchanged", drop_count, drop_exp);
    check("fp_count", fifo_count, DEPTH);
    wait_frames(6, 6 * FBT + 50);
    compare_frames("fp_frame");
    wait_idle("fp_idle");

    // Drop counter saturation
    for (int i = 0; i < 310; i++) begin
      golden_nonce = $urandom; golden_nonce_valid = 1'b1;
      tick();
    end
    golden_nonce_valid = 1'b0;
    check("sat_drop", drop_count, 8'hFF);

    // Reset mid-frame, while the line is low
    k = 0;
    while (uart_tx !== 1'b0 && k < 100) begin tick(); k++; end
    check("rstmid_line_low", uart_tx, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rstmid_tx", uart_tx, 1'b1);
    check("rstmid_count", fifo_count, 0);
    check("rstmid_drop", drop_count, 0);
    tick(2);
    reset_n = 1'b1;
    tick(FBT + 20);
    check("rstmid_tx_after", uart_tx, 1'b1);
    check("rstmid_busy_after", busy, 1'b0);
    check("framing_errors", ferr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
